// File: rtl/regfile_pkg.sv
// Shared types, default widths and power-on value helper for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;
  localparam int unsigned DEFAULT_NUM_READ   = 2;
  localparam int unsigned DEFAULT_SP_INDEX   = 29;
  localparam logic [31:0] DEFAULT_SP_INIT    = 32'h1c;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

  // Power-on value of an entry: 0 at index 0, sp_init at the stack pointer, otherwise the index.
  function automatic logic [31:0] init_value(
    input int unsigned idx,
    input int unsigned sp_index = DEFAULT_SP_INDEX,
    input logic [31:0] sp_init  = DEFAULT_SP_INIT
  );
    logic [31:0] result;
    if (idx == 0) begin
      result = '0;
    end else if (idx == sp_index) begin
      result = sp_init;
    end else begin
      result = idx;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_init_sweep.sv
// Re-initialisation sequencer: walks every entry index once, one per cycle, after init_request.
module regfile_init_sweep
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  init_request,
  output logic                  busy,
  output logic                  sweep_we,
  output logic [ADDR_WIDTH-1:0] sweep_idx
);

  sweep_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;

  // State, index and the registered status flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      busy     <= 1'b0;
      sweep_we <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      busy     <= (state_d == SWEEP);
      sweep_we <= (state_d == SWEEP);
    end
  end

  // Next state: start on request from IDLE, finish after the last index is written.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (init_request) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        idx_d = idx_q + ADDR_WIDTH'(1);
        if (idx_q == '1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sweep_idx = idx_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: NUM_READ registered read ports, two prioritised write ports,
// a zero register, a re-initialisation sweep and a debug read port.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned           ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned           NUM_READ   = DEFAULT_NUM_READ,
  parameter int unsigned           SP_INDEX   = DEFAULT_SP_INDEX,
  parameter logic [DATA_WIDTH-1:0] SP_INIT    = DATA_WIDTH'(DEFAULT_SP_INIT)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] read_address,
  output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
  input  logic [1:0]                     write_enable,
  input  logic [2*ADDR_WIDTH-1:0]        write_address,
  input  logic [2*DATA_WIDTH-1:0]        write_data_in,
  input  logic                           init_request,
  output logic                           busy,
  input  logic                           debug_request,
  input  logic [ADDR_WIDTH-1:0]          debug_address,
  output logic [DATA_WIDTH-1:0]          debug_data,
  output logic                           debug_valid
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  sweep_we;
  logic [ADDR_WIDTH-1:0] sweep_idx;

  logic [ADDR_WIDTH-1:0] wa_c  [2];
  logic [DATA_WIDTH-1:0] wd_c  [2];
  logic [1:0]            wr_acc_c;
  logic [ADDR_WIDTH-1:0] ra_c  [NUM_READ];
  logic [DATA_WIDTH-1:0] rd_c  [NUM_READ];

  function automatic logic [DATA_WIDTH-1:0] entry_init(input logic [ADDR_WIDTH-1:0] i);
    return DATA_WIDTH'(init_value(32'(i), SP_INDEX, 32'(SP_INIT)));
  endfunction

  regfile_init_sweep #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_init_sweep (
    .clock       (clock),
    .reset       (reset),
    .init_request(init_request),
    .busy        (busy),
    .sweep_we    (sweep_we),
    .sweep_idx   (sweep_idx)
  );

  // Unpack write ports and decide acceptance: non-zero address, not sweeping.
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      wa_c[w]     = write_address[w*ADDR_WIDTH +: ADDR_WIDTH];
      wd_c[w]     = write_data_in[w*DATA_WIDTH +: DATA_WIDTH];
      wr_acc_c[w] = write_enable[w] && (wa_c[w] != '0) && !busy;
    end
  end

  // Read mux per port; address 0 forced to zero, optional forwarding of accepted writes.
  always_comb begin
    for (int k = 0; k < NUM_READ; k++) begin
      ra_c[k] = read_address[k*ADDR_WIDTH +: ADDR_WIDTH];
      rd_c[k] = (ra_c[k] == '0) ? '0 : mem[ra_c[k]];
`ifdef REGFILE_BYPASS_EN
      if (ra_c[k] != '0) begin
        if (wr_acc_c[1] && (wa_c[1] == ra_c[k])) begin
          rd_c[k] = wd_c[1];
        end else if (wr_acc_c[0] && (wa_c[0] == ra_c[k])) begin
          rd_c[k] = wd_c[0];
        end
      end
`endif
    end
  end

  // Storage: reset and sweep restore init values; otherwise port 1 overrides port 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= entry_init(ADDR_WIDTH'(i));
      end
    end else if (sweep_we) begin
      mem[sweep_idx] <= entry_init(sweep_idx);
    end else begin
      if (wr_acc_c[0]) mem[wa_c[0]] <= wd_c[0];
      if (wr_acc_c[1]) mem[wa_c[1]] <= wd_c[1];
    end
  end

  // Registered datapath read ports.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_data <= '0;
    end else begin
      for (int k = 0; k < NUM_READ; k++) begin
        read_data[k*DATA_WIDTH +: DATA_WIDTH] <= rd_c[k];
      end
    end
  end

  // Debug read: samples storage before this edge's write, result held until the next request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      debug_valid <= 1'b0;
      debug_data  <= '0;
    end else begin
      debug_valid <= debug_request;
      if (debug_request) begin
        debug_data <= mem[debug_address];
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed, table-driven bench for register_file_mp (default parameters).
module tb_register_file_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  read_address = '0;
  logic [63:0] read_data;
  logic [1:0]  write_enable = '0;
  logic [9:0]  write_address = '0;
  logic [63:0] write_data_in = '0;
  logic        init_request = 1'b0;
  logic        busy;
  logic        debug_request = 1'b0;
  logic [4:0]  debug_address = '0;
  logic [31:0] debug_data;
  logic        debug_valid;

  int checks = 0;
  int errors = 0;
  int busy_cycles;

  register_file_mp dut (
    .clock        (clock),
    .reset        (reset),
    .read_address (read_address),
    .read_data    (read_data),
    .write_enable (write_enable),
    .write_address(write_address),
    .write_data_in(write_data_in),
    .init_request (init_request),
    .busy         (busy),
    .debug_request(debug_request),
    .debug_address(debug_address),
    .debug_data   (debug_data),
    .debug_valid  (debug_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  ra0, ra1;
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        dreq;
    logic [4:0]  dadr;
    logic [31:0] e0, e1;
    logic        edv;
    logic [31:0] edd;
  } vec_t;

  function automatic vec_t mk(input int ra0, input int ra1, input int we, input int wa0,
                              input int wa1, input logic [31:0] wd0, input logic [31:0] wd1,
                              input int dreq, input int dadr, input logic [31:0] e0,
                              input logic [31:0] e1, input int edv, input logic [31:0] edd);
    vec_t v;
    v.ra0 = 5'(ra0); v.ra1 = 5'(ra1); v.we = 2'(we);
    v.wa0 = 5'(wa0); v.wa1 = 5'(wa1); v.wd0 = wd0; v.wd1 = wd1;
    v.dreq = 1'(dreq); v.dadr = 5'(dadr);
    v.e0 = e0; v.e1 = e1; v.edv = 1'(edv); v.edd = edd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    write_enable  = '0;
    init_request  = 1'b0;
    debug_request = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = mk(0, 5,  0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h5, 0, 32'h0);
    vecs[1]  = mk(29, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h1c, 32'h0, 0, 32'h0);
    vecs[2]  = mk(7, 31, 3, 7, 7, 32'hDEADBEEF, 32'h12345678, 0, 0,
                  BYP ? 32'h12345678 : 32'h7, 32'd31, 0, 32'h0);
    vecs[3]  = mk(7, 0,  1, 0, 0, 32'hFFFFFFFF, 32'h0, 0, 0, 32'h12345678, 32'h0, 0, 32'h0);
    vecs[4]  = mk(0, 3,  1, 3, 0, 32'hA5A5A5A5, 32'h0, 0, 0,
                  32'h0, BYP ? 32'hA5A5A5A5 : 32'h3, 0, 32'h0);
    vecs[5]  = mk(3, 7,  0, 0, 0, 32'h0, 32'h0, 0, 0, 32'hA5A5A5A5, 32'h12345678, 0, 32'h0);
    vecs[6]  = mk(20, 21, 3, 21, 20, 32'h22, 32'h11, 0, 0,
                  BYP ? 32'h11 : 32'd20, BYP ? 32'h22 : 32'd21, 0, 32'h0);
    vecs[7]  = mk(21, 20, 0, 0, 0, 32'h0, 32'h0, 1, 29, 32'h22, 32'h11, 1, 32'h1c);
    vecs[8]  = mk(1, 2,  0, 0, 0, 32'h0, 32'h0, 1, 20, 32'h1, 32'h2, 1, 32'h11);
    vecs[9]  = mk(0, 0,  0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h11);
    vecs[10] = mk(5, 0,  1, 5, 0, 32'h55, 32'h0, 1, 5, BYP ? 32'h55 : 32'h5, 32'h0, 1, 32'h5);
    vecs[11] = mk(5, 0,  0, 0, 0, 32'h0, 32'h0, 1, 0, 32'h55, 32'h0, 1, 32'h0);

    // Reset state
    tick();
    tick();
    check("reset_rd0", read_data[31:0], 32'h0);
    check("reset_rd1", read_data[63:32], 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_dvalid", 32'(debug_valid), 32'h0);
    check("reset_ddata", debug_data, 32'h0);
    reset = 1'b0;

    // Table vectors
    for (int i = 0; i < 12; i++) begin
      read_address  = {vecs[i].ra1, vecs[i].ra0};
      write_enable  = vecs[i].we;
      write_address = {vecs[i].wa1, vecs[i].wa0};
      write_data_in = {vecs[i].wd1, vecs[i].wd0};
      debug_request = vecs[i].dreq;
      debug_address = vecs[i].dadr;
      tick();
      check($sformatf("vec%0d_rd0", i), read_data[31:0], vecs[i].e0);
      check($sformatf("vec%0d_rd1", i), read_data[63:32], vecs[i].e1);
      check($sformatf("vec%0d_dvalid", i), 32'(debug_valid), 32'(vecs[i].edv));
      check($sformatf("vec%0d_ddata", i), debug_data, vecs[i].edd);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
    end
    idle_inputs();

    // Sweep: write 10, then init with a same-cycle write to 11
    write_enable = 2'b01; write_address = {5'd0, 5'd10}; write_data_in = {32'h0, 32'hBEEF};
    tick();
    init_request = 1'b1;
    write_enable = 2'b01; write_address = {5'd0, 5'd11}; write_data_in = {32'h0, 32'h77};
    read_address = {5'd0, 5'd10};
    tick();
    check("sweep_start_rd10", read_data[31:0], 32'hBEEF);
    check("sweep_start_busy", 32'(busy), 32'h1);
    busy_cycles = 1;
    for (int i = 1; i <= 64; i++) begin
      init_request  = (i == 1);
      write_enable  = (i == 20) ? 2'b11 : 2'b00;
      write_address = {5'd12, 5'd5};
      write_data_in = {32'h9999, 32'hDEAD};
      read_address  = {5'd0, 5'd11};
      debug_request = (i == 3);
      debug_address = 5'd10;
      tick();
      if (i == 1) check("sweep_rd11_pre", read_data[31:0], 32'h77);
      if (i == 3) begin
        check("sweep_dbg_valid", 32'(debug_valid), 32'h1);
        check("sweep_dbg_data", debug_data, 32'hBEEF);
      end
      if (!busy) break;
      busy_cycles++;
    end
    check("sweep_busy_cycles", 32'(busy_cycles), 32'd32);
    idle_inputs();
    read_address = {5'd12, 5'd10};
    tick();
    check("post_sweep_rd10", read_data[31:0], 32'hA);
    check("post_sweep_rd12", read_data[63:32], 32'hC);
    read_address = {5'd11, 5'd5};
    tick();
    check("post_sweep_rd5", read_data[31:0], 32'h5);
    check("post_sweep_rd11", read_data[63:32], 32'hB);

    // Reset in the middle of a sweep
    write_enable = 2'b11; write_address = {5'd29, 5'd20}; write_data_in = {32'hFFFF, 32'h1234};
    tick();
    idle_inputs();
    read_address = {5'd29, 5'd20};
    init_request = 1'b1;
    tick();
    init_request = 1'b0;
    repeat (15) tick();
    check("midsweep_busy", 32'(busy), 32'h1);
    check("midsweep_rd20", read_data[31:0], 32'h1234);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_rd0", read_data[31:0], 32'h0);
    check("rst_mid_ddata", debug_data, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    tick();
    check("rst_mid_rd20", read_data[31:0], 32'd20);
    check("rst_mid_rd29", read_data[63:32], 32'h1c);
    check("rst_mid_busy_after", 32'(busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
